// File: rtl/serial_a_paralelo_align.sv
// Serial-to-parallel receive front end: hunts for word alignment on a sync nibble,
// locks after SYNC_COUNT aligned syncs, then publishes each word with a valid flag.
module serial_a_paralelo_align #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] SYNC_WORD  = 4'hC,
    parameter int               SYNC_COUNT = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             word_strobe,
    output logic             active
);

    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int SCW = $clog2(SYNC_COUNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    bit_cnt;
    logic [SCW-1:0]   sync_cnt;

    logic [WIDTH-1:0] w;
    logic             boundary;
    logic             is_sync;

    // w is the shift register including the bit being sampled this edge
    assign w        = {sh[WIDTH-2:0], data_in};
    assign boundary = (bit_cnt == CW'(WIDTH - 1));
    assign is_sync  = (w == SYNC_WORD);

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state       <= HUNT;
            sh          <= '0;
            bit_cnt     <= '0;
            sync_cnt    <= '0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            word_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            sh          <= w;
            bit_cnt     <= boundary ? '0 : bit_cnt + CW'(1);
            // NOTE: default-low strobe; a later non-blocking assignment in this block wins.
            word_strobe <= 1'b0;
            case (state)
                HUNT: begin
                    if (is_sync) begin
                        bit_cnt  <= '0;
                        sync_cnt <= SCW'(1);
                        if (SYNC_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (boundary) begin
                        if (is_sync) begin
                            sync_cnt <= sync_cnt + SCW'(1);
                            if (sync_cnt + SCW'(1) == SCW'(SYNC_COUNT)) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state    <= HUNT;
                            sync_cnt <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary) begin
                        data_out    <= w;
                        valid_out   <= !is_sync;
                        word_strobe <= 1'b1;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_a_paralelo_align.sv
// Self-checking bench for serial_a_paralelo_align: directed scenarios plus random
// bit streams, compared every cycle against a bit-index based reference model.
module tb_serial_a_paralelo_align;

    localparam int         WIDTH = 4;
    localparam logic [3:0] SYNC  = 4'hC;
    localparam int         SC    = 4;

    logic             clk_8f = 1'b0;
    logic             reset  = 1'b1;
    logic             data_in = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             word_strobe;
    logic             active;

    int checks = 0;
    int errors = 0;

    // reference model state
    int   m_win;
    int   m_t;
    int   m_anchor;
    int   m_syncs;
    bit   m_counting;
    bit   m_locked;
    logic [3:0] exp_data;
    logic exp_valid;
    logic exp_strobe;
    logic exp_active;

    serial_a_paralelo_align #(
        .WIDTH(WIDTH),
        .SYNC_WORD(SYNC),
        .SYNC_COUNT(SC)
    ) dut (
        .clk_8f(clk_8f),
        .reset(reset),
        .data_in(data_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .word_strobe(word_strobe),
        .active(active)
    );

    always #5 clk_8f = ~clk_8f;

    // Model: words are counted by absolute bit index relative to the anchoring sync.
    task automatic model_step(input bit rst, input bit b);
        bit on_phase;
        if (rst) begin
            m_win = 0; m_t = 0; m_anchor = 0; m_syncs = 0;
            m_counting = 0; m_locked = 0;
            exp_data = '0; exp_valid = 0; exp_strobe = 0; exp_active = 0;
            return;
        end
        m_win = (m_win * 2 + int'(b)) % 16;
        on_phase = ((m_t - m_anchor) % WIDTH) == 0;
        exp_strobe = 0;
        if (m_locked) begin
            if (on_phase) begin
                exp_data   = 4'(m_win);
                exp_valid  = (m_win != int'(SYNC));
                exp_strobe = 1;
            end
        end else if (m_counting) begin
            if (on_phase) begin
                if (m_win == int'(SYNC)) begin
                    m_syncs++;
                    if (m_syncs == SC) begin
                        m_locked = 1; m_counting = 0; exp_active = 1;
                    end
                end else begin
                    m_counting = 0; m_syncs = 0;
                end
            end
        end else if (m_win == int'(SYNC)) begin
            m_anchor = m_t; m_syncs = 1;
            if (SC == 1) begin
                m_locked = 1; exp_active = 1;
            end else begin
                m_counting = 1;
            end
        end
        m_t++;
    endtask

    task automatic drive_bit(input bit b);
        @(negedge clk_8f);
        reset   = 1'b0;
        data_in = b;
        @(posedge clk_8f);
        #1;
        model_step(0, b);
        checks++;
        if (word_strobe !== exp_strobe) begin
            errors++;
            $display("FAIL strobe t=%0d: got %b expected %b", m_t, word_strobe, exp_strobe);
        end
        checks++;
        if (active !== exp_active) begin
            errors++;
            $display("FAIL active t=%0d: got %b expected %b", m_t, active, exp_active);
        end
        checks++;
        if (data_out !== exp_data) begin
            errors++;
            $display("FAIL data_out t=%0d: got %h expected %h", m_t, data_out, exp_data);
        end
        checks++;
        if (valid_out !== exp_valid) begin
            errors++;
            $display("FAIL valid_out t=%0d: got %b expected %b", m_t, valid_out, exp_valid);
        end
    endtask

    task automatic drive_word(input logic [3:0] wv);
        for (int i = 3; i >= 0; i--) drive_bit(wv[i]);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_8f);
            reset   = 1'b1;
            data_in = 1'($urandom);
            @(posedge clk_8f);
            #1;
            model_step(1, 1'b0);
            checks++;
            if ({data_out, valid_out, word_strobe, active} !== 7'd0) begin
                errors++;
                $display("FAIL reset_outputs: got data=%h valid=%b strobe=%b active=%b expected all 0",
                         data_out, valid_out, word_strobe, active);
            end
        end
    endtask

    task automatic lock_up();
        do_reset(1);
        for (int i = 0; i < SC; i++) drive_word(SYNC);
    endtask

    task automatic test_reset();
        do_reset(3);
        for (int i = 0; i < 8; i++) begin
            drive_bit(1'b0);
            checks++;
            if (word_strobe !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got strobe=%b active=%b expected 0 0", word_strobe, active);
            end
        end
    endtask

    task automatic test_aligned_lock();
        do_reset(1);
        for (int i = 0; i < SC; i++) begin
            checks++;
            if (active !== 1'b0) begin
                errors++;
                $display("FAIL t2_active_early: got %b expected 0", active);
            end
            drive_word(SYNC);
        end
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL t2_active_after_lock: got %b expected 1", active);
        end
        drive_word(4'hA);
        checks++;
        if (word_strobe !== 1'b1 || data_out !== 4'hA || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL t2_first_word: got strobe=%b data=%h valid=%b expected 1 a 1",
                     word_strobe, data_out, valid_out);
        end
        for (int i = 0; i < 3; i++) begin
            drive_bit(SYNC[3 - i]);
            checks++;
            if (word_strobe !== 1'b0 || data_out !== 4'hA || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL t2_hold: got strobe=%b data=%h valid=%b expected 0 a 1",
                         word_strobe, data_out, valid_out);
            end
        end
        drive_bit(SYNC[0]);
    endtask

    task automatic test_misaligned();
        do_reset(1);
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
        for (int i = 0; i < SC; i++) drive_word(SYNC);
        drive_word(4'h5);
        checks++;
        if (word_strobe !== 1'b1 || data_out !== 4'h5 || valid_out !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL t3_offset_lock: got strobe=%b data=%h valid=%b active=%b expected 1 5 1 1",
                     word_strobe, data_out, valid_out, active);
        end
    endtask

    task automatic test_broken_lock();
        do_reset(1);
        drive_word(SYNC); drive_word(SYNC); drive_word(4'h6);
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL t4_broken_active: got %b expected 0", active);
        end
        for (int i = 0; i < SC; i++) drive_word(SYNC);
        drive_word(4'h3);
        checks++;
        if (word_strobe !== 1'b1 || data_out !== 4'h3 || active !== 1'b1) begin
            errors++;
            $display("FAIL t4_relock: got strobe=%b data=%h active=%b expected 1 3 1",
                     word_strobe, data_out, active);
        end
    endtask

    task automatic test_idle_in_active();
        logic [3:0] words [3] = '{4'h9, 4'hC, 4'hF};
        logic       vals  [3] = '{1'b1, 1'b0, 1'b1};
        lock_up();
        for (int i = 0; i < 3; i++) begin
            drive_word(words[i]);
            checks++;
            if (word_strobe !== 1'b1 || data_out !== words[i] || valid_out !== vals[i] || active !== 1'b1) begin
                errors++;
                $display("FAIL t5_word%0d: got strobe=%b data=%h valid=%b active=%b expected 1 %h %b 1",
                         i, word_strobe, data_out, valid_out, active, words[i], vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid_active();
        lock_up();
        drive_word(4'h7);
        drive_bit(1'b1); drive_bit(1'b0);
        do_reset(1);
        for (int i = 0; i < SC - 1; i++) drive_word(SYNC);
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL t6_early_relock: got %b expected 0", active);
        end
        drive_word(SYNC);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL t6_relock: got %b expected 1", active);
        end
    endtask

    task automatic test_random_stream();
        do_reset(1);
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0, 1: drive_word(SYNC);
                2:    drive_word(4'($urandom));
                default: drive_bit(1'($urandom));
            endcase
            if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 2));
        end
    endtask

    initial begin
        test_reset();
        test_aligned_lock();
        test_misaligned();
        test_broken_lock();
        test_idle_in_active();
        test_reset_mid_active();
        test_random_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
